// File: rtl/enemy_lanes.sv
// enemy_lanes: multi-slot falling-car controller and renderer.
//
// Each slot runs an independent PARKED/FALLING/FROZEN machine advanced on the
// logic tick. The highest-priority (lowest index) visible car drives one shared
// external sprite ROM through a two-stage pixel pipeline.
//
// Ports:
//   clk          - pixel/system clock
//   reset        - asynchronous active-low reset
//   tick         - one-cycle logic-rate strobe
//   enable       - global spawn permission
//   spawn_req    - per-slot spawn request, sampled on tick
//   lane_x       - per-slot x position, slot i at [10i+9:10i]
//   speed        - pixels advanced per tick
//   collision    - level input, freezes falling cars
//   restart      - synchronous pulse, parks every slot
//   hcount/vcount- current VGA scan coordinates
//   rom_addr     - sprite ROM address (registered)
//   rom_data     - sprite ROM colour, valid one cycle after rom_addr
//   pos_x        - lane_x passed through
//   pos_y        - registered y per slot
//   active       - slot is FALLING or FROZEN
//   passed       - one-cycle despawn pulse per slot
//   passed_count - saturating despawn count
//   data         - pixel colour
//   data_valid   - data is an opaque enemy pixel
module enemy_lanes #(
    parameter int         NUM_ENEMIES  = 3,
    parameter int         SPRITE_W     = 80,
    parameter int         SPRITE_H     = 121,
    parameter int         SCREEN_LIMIT = 600,
    parameter int         PARK_Y       = 620,
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter int         ADDR_W       = 14,
    parameter logic [2:0] TRANSPARENT  = 3'b000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      enable,
    input  logic [NUM_ENEMIES-1:0]    spawn_req,
    input  logic [10*NUM_ENEMIES-1:0] lane_x,
    input  logic [3:0]                speed,
    input  logic                      collision,
    input  logic                      restart,
    input  logic [9:0]                hcount,
    input  logic [9:0]                vcount,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [2:0]                rom_data,
    output logic [10*NUM_ENEMIES-1:0] pos_x,
    output logic [10*NUM_ENEMIES-1:0] pos_y,
    output logic [NUM_ENEMIES-1:0]    active,
    output logic [NUM_ENEMIES-1:0]    passed,
    output logic [7:0]                passed_count,
    output logic [2:0]                data,
    output logic                      data_valid
);

    localparam logic [1:0] PARKED  = 2'd0;
    localparam logic [1:0] FALLING = 2'd1;
    localparam logic [1:0] FROZEN  = 2'd2;

    localparam logic [10:0] LIMIT11 = 11'(SCREEN_LIMIT);
    localparam logic [10:0] SW11    = 11'(SPRITE_W);
    localparam logic [10:0] SH11    = 11'(SPRITE_H);
    localparam logic [9:0]  HACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  VACT    = 10'(V_ACTIVE);

    logic [NUM_ENEMIES-1:0][1:0]        state;
    logic [NUM_ENEMIES-1:0][9:0]        y_q;
    logic [NUM_ENEMIES-1:0][10:0]       sum;
    logic [NUM_ENEMIES-1:0]             despawn;
    logic [3:0]                         n_despawn;
    logic [8:0]                         cnt_sum;
    logic [NUM_ENEMIES-1:0]             slot_hit;
    logic [NUM_ENEMIES-1:0][ADDR_W-1:0] slot_addr;
    logic                               hit_any;
    logic [ADDR_W-1:0]                  addr_next;
    logic                               hit_q;
    logic                               hit_qq;

    assign pos_x = lane_x;
    assign pos_y = y_q;

    // Despawn decision shares the 11-bit sum with the move path; restart and
    // collision both pre-empt it.
    always_comb begin
        sum       = '0;
        despawn   = '0;
        n_despawn = '0;
        active    = '0;
        for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
            sum[i]     = {1'b0, y_q[i]} + {7'd0, speed};
            despawn[i] = tick && !restart && !collision &&
                         (state[i] == FALLING) && (sum[i] >= LIMIT11);
            n_despawn  = n_despawn + {3'd0, despawn[i]};
            active[i]  = (state[i] == FALLING) || (state[i] == FROZEN);
        end
        cnt_sum = {1'b0, passed_count} + {5'd0, n_despawn};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
                state[i] <= PARKED;
                y_q[i]   <= 10'(PARK_Y);
            end
            passed       <= '0;
            passed_count <= '0;
        end else begin
            passed       <= despawn;
            passed_count <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
            for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
                if (restart) begin
                    state[i] <= PARKED;
                    y_q[i]   <= 10'(PARK_Y);
                end else begin
                    case (state[i])
                        PARKED: begin
                            if (tick && enable && spawn_req[i]) begin
                                state[i] <= FALLING;
                                y_q[i]   <= '0;
                            end
                        end
                        FALLING: begin
                            if (collision) begin
                                state[i] <= FROZEN;
                            end else if (despawn[i]) begin
                                state[i] <= PARKED;
                                y_q[i]   <= 10'(PARK_Y);
                            end else if (tick) begin
                                y_q[i] <= sum[i][9:0];
                            end
                        end
                        FROZEN: ;
                        default: begin
                            state[i] <= PARKED;
                            y_q[i]   <= 10'(PARK_Y);
                        end
                    endcase
                end
            end
        end
    end

    // Per-slot hit test at 11 bits so pos + size never wraps.
    always_comb begin
        slot_hit  = '0;
        slot_addr = '0;
        for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
            slot_hit[i] = active[i] && (vcount < VACT) && (hcount < HACT) &&
                          ({1'b0, vcount} >= {1'b0, y_q[i]}) &&
                          ({1'b0, vcount} <  {1'b0, y_q[i]} + SH11) &&
                          ({1'b0, hcount} >= {1'b0, lane_x[10*i +: 10]}) &&
                          ({1'b0, hcount} <  {1'b0, lane_x[10*i +: 10]} + SW11);
            slot_addr[i] = ADDR_W'(vcount - y_q[i]) * ADDR_W'(SPRITE_W) +
                           ADDR_W'(hcount - lane_x[10*i +: 10]);
        end
    end

    // Lowest index wins on overlap.
    always_comb begin
        hit_any   = 1'b0;
        addr_next = '0;
        for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
            if (slot_hit[i] && !hit_any) begin
                hit_any   = 1'b1;
                addr_next = slot_addr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr <= '0;
            hit_q    <= 1'b0;
            hit_qq   <= 1'b0;
        end else begin
            rom_addr <= addr_next;
            hit_q    <= hit_any;
            hit_qq   <= hit_q;
        end
    end

    // The ROM registers the address itself, so stage 2 is the ROM output gated
    // by the twice-delayed hit flag rather than another register.
    assign data       = hit_qq ? rom_data : 3'b000;
    assign data_valid = hit_qq && (rom_data != TRANSPARENT);

endmodule

// File: doc/enemy_lanes.md
# enemy_lanes

Parametrised multi-enemy controller for the road scene. Moves up to `NUM_ENEMIES` falling cars, each in its own lane, on a single system clock driven by a logic-tick strobe. Draws the highest-priority visible car through one shared, externally instantiated sprite ROM. Sits between the game-logic tick generator, the collision detector and the VGA pixel mux; it replaces the single-enemy mover/renderer.

## Interface
- `NUM_ENEMIES`, 3: number of independent enemy slots (1..8).
- `SPRITE_W`, 80: sprite width in pixels.
- `SPRITE_H`, 121: sprite height in lines.
- `SCREEN_LIMIT`, 600: y value at which a car leaves the track.
- `PARK_Y`, 620: y value held by an idle car, which is off-screen.
- `H_ACTIVE` / `V_ACTIVE`, 640 / 480: visible area.
- `ADDR_W`, 14: sprite ROM address width. Requires `SPRITE_W*SPRITE_H <= 2**ADDR_W`.
- `TRANSPARENT`, 3'b000: ROM colour treated as see-through.

Ports:
- `clk`, in, 1: pixel/system clock; the only clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-cycle logic-rate strobe.
- `enable`, in, 1: global spawn permission.
- `spawn_req`, in, `NUM_ENEMIES`: per-slot spawn request, sampled on `tick`.
- `lane_x`, in, `10*NUM_ENEMIES`: per-slot x position; slot i occupies bits [10i+9:10i].
- `speed`, in, 4: pixels advanced per tick; 0 means hold.
- `collision`, in, 1: level input; freezes all moving cars.
- `restart`, in, 1: synchronous pulse; parks every slot.
- `hcount`, `vcount`, in, 10 each: current VGA coordinates.
- `rom_addr`, out, `ADDR_W`: address to the shared sprite ROM.
- `rom_data`, in, 3: ROM output, valid one cycle after `rom_addr`.
- `pos_x`, out, `10*NUM_ENEMIES`: equals `lane_x`, passed through combinationally.
- `pos_y`, out, `10*NUM_ENEMIES`: registered y position per slot.
- `active`, out, `NUM_ENEMIES`: 1 while a slot is FALLING or FROZEN.
- `passed`, out, `NUM_ENEMIES`: one-cycle pulse when a slot despawns at the bottom.
- `passed_count`, out, 8: saturating count of despawns.
- `data`, out, 3: pixel colour.
- `data_valid`, out, 1: `data` is opaque enemy pixel.

## Operation
Each slot has its own state machine, updated only on cycles where `tick`=1 unless noted.
- **PARKED → FALLING**: on `spawn_req[i]` & `enable`. `pos_y` is set to 0.
- **FALLING → PARKED**: when `pos_y + speed >= SCREEN_LIMIT`.
  - Sum is evaluated at 11 bits, so there is no wrap.
  - `pos_y` is set to `PARK_Y`.
  - `passed[i]` pulses.
  - `passed_count` increments and saturates at 255.
- **FALLING**, otherwise: `pos_y` is set to `pos_y + speed`.
- **FALLING → FROZEN**: when `collision`=1. This transition is evaluated every cycle, independent of `tick`, and `pos_y` holds.
- **FROZEN**: exits only via `restart` or `reset`. `collision` falling does not resume movement.
- **`restart`**: evaluated every cycle. All slots go to PARKED with `pos_y` = `PARK_Y`. `passed_count` is not cleared.
- **Priority**: `restart` > `collision` > despawn > move > spawn.
- `spawn_req` to a non-PARKED slot is ignored. Several slots may spawn on the same tick.
- **Reset values**: all slots PARKED, `pos_y` = `PARK_Y`, `active`=0, `passed`=0, `passed_count`=0, `rom_addr`=0, `data`=0, `data_valid`=0.

Render path, active every cycle:
- **Slot hit**: slot i is hit when all of the following hold:
  - `active[i]`;
  - `vcount < V_ACTIVE` and `hcount < H_ACTIVE`;
  - `pos_y <= vcount < pos_y + SPRITE_H`;
  - `pos_x <= hcount < pos_x + SPRITE_W`.
- **Overlap**: the lowest index wins.
- **Address**: `rom_addr` = `(vcount - pos_y)*SPRITE_W + (hcount - pos_x)` for the winner; 0 if there is no hit. The address is computed, not incremented, so it is independent of scan history.

## Timing
- **Stage 0 → 1**: hit detection and address computation are registered into `rom_addr` and a hit flag.
- **Stage 2**:
  - `data` = `rom_data`.
  - `data_valid` = hit & (`rom_data` != `TRANSPARENT`).
  - `data` = 0 when there is no hit.
- **Latency**: 2 clocks from `hcount`/`vcount` to `data`. The downstream mux delays its own coordinates to match.
- **`pos_y` update**: visible the cycle after `tick`. `passed` is high for exactly that one cycle.
- **Freeze latency**: one cycle after `collision` rises.
- **Mid-operation reset**: asserting `reset` forces all reset values immediately. Deassertion is synchronised by the integrator; this block expects it clean.

## Test plan
- **Spawn and fall**: `reset` released, `enable`=1, `speed`=1, `spawn_req`=3'b001, one tick.
  - Required: `pos_y[0]`=0, `active`=3'b001.
  - After 5 further ticks, `pos_y[0]`=5.
  - `pos_y[1]` and `pos_y[2]` stay at 620.
- **Despawn**: slot 0 at 598, `speed`=3, one tick.
  - Required: `pos_y[0]`=620, `passed[0]` pulses for exactly 1 cycle, `passed_count` goes 0→1.
  - `speed`=1 from `pos_y`=599 also despawns.
- **Freeze**: `collision` pulsed for 1 cycle while slots 0 and 1 are FALLING, then ticks continue.
  - Required: both y positions hold, `active` stays 1.
  - `restart` then parks both at 620.
- **Render**: slot 1 at `lane_x`=100, `pos_y`=50, scan (`hcount`,`vcount`)=(110,52).
  - Required: `rom_addr`=2*80+10=170 one cycle later.
  - `data` equals ROM content 2 cycles later.
  - A ROM value of 000 gives `data_valid`=0.
- **Overlap and boundaries**:
  - Slots 0 and 2 both cover a pixel: slot 0's address is used.
  - `hcount`=`lane_x`+80 or `vcount`=`pos_y`+121 gives no hit.
  - `vcount`=480 gives no hit.
- **Priority and saturation**:
  - `restart` and a spawning tick in the same cycle: all slots PARKED.
  - 256 despawns: `passed_count` stays 255.
